gray_step_counter: RTL



---
 rtl/gray_step_counter_pkg.sv | 13 +
 rtl/gray_step_counter_bin2gray_comb.sv | 11 +
 rtl/gray_step_counter.sv | 75 +++++++
 3 files changed

// File: rtl/gray_step_counter_pkg.sv
// Shared constants and the reference binary-to-Gray function for the Gray step counter
// and for checkers of the downstream converter.
package gray_step_counter_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned MaxWidth     = 16;

  // Widest legal code; callers truncate to their own width.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/gray_step_counter_bin2gray_comb.sv
// Width-parameterised combinational binary-to-Gray converter.
module bin2gray_comb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_step_counter.sv
// Registered up/down counter presenting binary and Gray count together, plus a one-hot
// toggled-bit pulse and a wrap pulse.
module gray_step_counter
  import gray_step_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] gray_chg,
  output logic             tc
);

  localparam logic [WIDTH-1:0] InitBin  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] InitGray = InitBin ^ (InitBin >> 1);

  logic [WIDTH-1:0] bin_q, bin_next, bin_step;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             tc_q, tc_d;
  logic             step, wrap;

  always_comb begin
    step     = en & ~load;
    bin_step = up ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
    wrap     = up ? (bin_q == '1) : (bin_q == '0);

    bin_next = bin_q;
    if (load) begin
      bin_next = load_val;
    end else if (en) begin
      bin_next = bin_step;
    end
  end

  // Converting the selected next value keeps binary and Gray in the same register stage.
  bin2gray_comb #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_d)
  );

  always_comb begin
    chg_d = step ? (gray_q ^ gray_d) : '0;
    tc_d  = step & wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= InitBin;
      gray_q <= InitGray;
      chg_q  <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_d;
      chg_q  <= chg_d;
      tc_q   <= tc_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign gray_chg = chg_q;
  assign tc       = tc_q;

endmodule
